// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode/state encodings and datapath select constants shared by ctrl_unit.
package ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_LDI   = 4'd4,
        OP_SUB   = 4'd5,
        OP_JMPZ  = 4'd6,
        OP_HALT  = 4'd7
    } opcode_e;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_LDI    = 4'd8,
        S_JMPZ   = 4'd9,
        S_HALT   = 4'd10
    } state_e;

    localparam logic [1:0] RFS_ALU = 2'd0;
    localparam logic [1:0] RFS_MEM = 2'd1;
    localparam logic [1:0] RFS_IMM = 2'd2;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/pc_ir.sv
// pc_ir: program counter and instruction register; a jump target overrides the increment.
module pc_ir #(
    parameter int PC_W = 7,
    parameter int IW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_ir,
    input  logic            inc,
    input  logic            ld_tgt,
    input  logic [IW-1:0]   i_data,
    output logic [PC_W-1:0] pc,
    output logic [IW-1:0]   ir
);
    logic [PC_W-1:0] pc_d, pc_q;
    logic [IW-1:0]   ir_d, ir_q;

    always_comb begin
        pc_d = ld_tgt ? ir_q[PC_W+3:4] : inc ? pc_q + PC_W'(1) : pc_q;
        ir_d = ld_ir ? i_data : ir_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

    assign pc = pc_q;
    assign ir = ir_q;
endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: multi-cycle fetch/decode/execute sequencer driving the data-memory/register-file datapath.
module ctrl_unit #(
    parameter int PC_W = 7,
    parameter int IW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [IW-1:0]   I_data,
    input  logic            RF_Ra_zero,
    output logic [PC_W-1:0] PC_addr,
    output logic            I_rd,
    output logic [7:0]      D_addr,
    output logic            D_rd,
    output logic            D_wr,
    output logic [1:0]      RF_s,
    output logic [7:0]      RF_W_data,
    output logic [4:0]      RF_W_addr,
    output logic            RF_W_wr,
    output logic [4:0]      RF_Ra_addr,
    output logic [4:0]      RF_Rb_addr,
    output logic [2:0]      ALU_s0,
    output logic [3:0]      state_o
);
    import ctrl_pkg::*;

    state_e          state_d, state_q;
    logic            i_rd_d, i_rd_q, d_rd_d, d_rd_q, d_wr_d, d_wr_q, rf_w_wr_d, rf_w_wr_q;
    logic [1:0]      rf_s_d, rf_s_q;
    logic [2:0]      alu_d, alu_q;
    logic [IW-1:0]   ir;
    logic [PC_W-1:0] pc;

    pc_ir #(.PC_W(PC_W), .IW(IW)) u_pc_ir (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld_ir  (state_q == S_DECODE),
        .inc    (state_q == S_DECODE),
        .ld_tgt (state_q == S_JMPZ && RF_Ra_zero),
        .i_data (I_data),
        .pc     (pc),
        .ir     (ir)
    );

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE:
                case (opcode_e'(I_data[IW-1:IW-4]))
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_LDI:   state_d = S_LDI;
                    OP_SUB:   state_d = S_SUB;
                    OP_JMPZ:  state_d = S_JMPZ;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_FETCH;
                endcase
            S_LOAD_A: state_d = S_LOAD_B;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
        // Controls are registered from the next state so each is a clean flop output.
        i_rd_d    = state_d == S_FETCH;
        d_rd_d    = state_d == S_LOAD_A;
        d_wr_d    = state_d == S_STORE;
        rf_w_wr_d = state_d inside {S_LOAD_B, S_ADD, S_SUB, S_LDI};
        rf_s_d    = state_d == S_LOAD_B ? RFS_MEM : state_d == S_LDI ? RFS_IMM : RFS_ALU;
        alu_d     = state_d == S_ADD ? ALU_ADD : state_d == S_SUB ? ALU_SUB : ALU_PASS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            i_rd_q    <= 1'b0;
            d_rd_q    <= 1'b0;
            d_wr_q    <= 1'b0;
            rf_w_wr_q <= 1'b0;
            rf_s_q    <= RFS_ALU;
            alu_q     <= ALU_PASS;
        end else begin
            state_q   <= state_d;
            i_rd_q    <= i_rd_d;
            d_rd_q    <= d_rd_d;
            d_wr_q    <= d_wr_d;
            rf_w_wr_q <= rf_w_wr_d;
            rf_s_q    <= rf_s_d;
            alu_q     <= alu_d;
        end
    end

    assign PC_addr    = pc;
    assign I_rd       = i_rd_q;
    assign D_rd       = d_rd_q;
    assign D_wr       = d_wr_q & rst_n;
    assign RF_W_wr    = rf_w_wr_q & rst_n;
    assign RF_s       = rf_s_q;
    assign ALU_s0     = alu_q;
    assign state_o    = state_q;
    assign D_addr     = ir[11:4];
    assign RF_W_data  = ir[11:4];
    assign RF_W_addr  = {1'b0, ir[3:0]};
    // STORE names its source register in the low nibble; everything else uses IR[11:8].
    assign RF_Ra_addr = {1'b0, ir[IW-1:IW-4] == OP_STORE ? ir[3:0] : ir[11:8]};
    assign RF_Rb_addr = {1'b0, ir[7:4]};
endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: instruction-level reference model feeds an event scoreboard checked by a monitor.
module tb_ctrl_unit;
    import ctrl_pkg::*;

    typedef struct packed {
        int          cyc;
        logic [3:0]  en;
        logic [42:0] val;
        logic [42:0] msk;
    } ev_t;

    logic        clk = 1'b0, rst_n = 1'b0, RF_Ra_zero;
    logic [15:0] I_data = '0;
    logic [6:0]  PC_addr;
    logic        I_rd, D_rd, D_wr, RF_W_wr;
    logic [7:0]  D_addr, RF_W_data;
    logic [1:0]  RF_s;
    logic [4:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic [3:0]  state_o;

    logic [15:0] rom [128];
    logic [15:0] zero_v = '0;
    int          cnt = 0, n_cmp = 0, n_bad = 0;
    ev_t         q[$];
    ev_t         e;
    logic [42:0] act;
    logic [3:0]  en;

    ctrl_unit dut (
        .clk(clk), .rst_n(rst_n), .I_data(I_data), .RF_Ra_zero(RF_Ra_zero),
        .PC_addr(PC_addr), .I_rd(I_rd), .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr),
        .RF_s(RF_s), .RF_W_data(RF_W_data), .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .ALU_s0(ALU_s0), .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;
    always @(posedge clk) if (I_rd) I_data <= rom[PC_addr];
    assign RF_Ra_zero = zero_v[RF_Ra_addr[3:0]];

    function automatic logic [42:0] pk(logic [6:0] pc, logic [7:0] da, logic [1:0] s, logic [7:0] wd,
                                       logic [4:0] wa, logic [4:0] ra, logic [4:0] rb, logic [2:0] alu);
        return {pc, da, s, wd, wa, ra, rb, alu};
    endfunction

    function automatic void push(int c, int lim, logic [3:0] ev_en, logic [42:0] v, logic [42:0] m);
        if (c <= lim) q.push_back('{c, ev_en, v, m});
    endfunction

    // Walks the program one instruction at a time using the documented cycles-per-instruction.
    task automatic model(input int c0, input int lim, output bit halted);
        logic [6:0]  pc;
        logic [15:0] ins;
        int          c;
        pc = '0;
        c = c0;
        halted = 1'b0;
        while (c <= lim) begin
            ins = rom[pc];
            push(c, lim, 4'b1000, pk(pc, '0, '0, '0, '0, '0, '0, '0), pk('1, '0, '0, '0, '0, '0, '0, '0));
            pc = pc + 7'd1;
            case (ins[15:12])
                4'd1: begin
                    push(c + 2, lim, 4'b0010, pk('0, ins[11:4], '0, '0, '0, {1'b0, ins[3:0]}, '0, '0),
                         pk('0, '1, '0, '0, '0, '1, '0, '0));
                    c += 3;
                end
                4'd2: begin
                    push(c + 2, lim, 4'b0100, pk('0, ins[11:4], '0, '0, '0, '0, '0, '0),
                         pk('0, '1, '0, '0, '0, '0, '0, '0));
                    push(c + 3, lim, 4'b0001, pk('0, ins[11:4], 2'd1, '0, {1'b0, ins[3:0]}, '0, '0, '0),
                         pk('0, '1, '1, '0, '1, '0, '0, '0));
                    c += 4;
                end
                4'd3, 4'd5: begin
                    push(c + 2, lim, 4'b0001,
                         pk('0, '0, 2'd0, '0, {1'b0, ins[3:0]}, {1'b0, ins[11:8]}, {1'b0, ins[7:4]},
                            ins[15:12] == 4'd3 ? 3'd1 : 3'd2),
                         pk('0, '0, '1, '0, '1, '1, '1, '1));
                    c += 3;
                end
                4'd4: begin
                    push(c + 2, lim, 4'b0001, pk('0, '0, 2'd2, ins[11:4], {1'b0, ins[3:0]}, '0, '0, '0),
                         pk('0, '0, '1, '1, '1, '0, '0, '0));
                    c += 3;
                end
                4'd6: begin
                    if (zero_v[ins[11:8]]) pc = ins[10:4];
                    c += 3;
                end
                4'd7: begin
                    halted = (c + 2 <= lim);
                    c = lim + 1;
                end
                default: c += 2;
            endcase
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({PC_addr, I_rd, D_addr, D_rd, D_wr, RF_s, RF_W_data, RF_W_addr, RF_W_wr,
             RF_Ra_addr, RF_Rb_addr, ALU_s0, state_o} !== {63'd0, S_INIT}) begin
            n_bad++;
            $display("FAIL reset_state: got pc=%h state=%0d en=%b%b%b%b, required all zero, state %0d",
                     PC_addr, state_o, I_rd, D_rd, D_wr, RF_W_wr, S_INIT);
        end
        q.delete();
        rst_n = 1'b1;
    endtask

    task automatic run(input int len, input string nm);
        bit h;
        int base;
        do_reset();
        base = cnt;
        model(base + 1, base + len, h);
        while (cnt < base + len) @(negedge clk);
        #2;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL %s missing_events: got %0d still pending, required 0 (next cyc %0d)", nm, q.size(), q[0].cyc);
        end
        if (h) begin
            n_cmp++;
            if (state_o !== S_HALT) begin
                n_bad++;
                $display("FAIL %s halt_state: got %0d, required %0d", nm, state_o, S_HALT);
            end
        end
    endtask

    task automatic fill_rom(input logic [15:0] v);
        for (int i = 0; i < 128; i++) rom[i] = v;
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                en = {I_rd, D_rd, D_wr, RF_W_wr};
                if (rst_n && en != 4'b0000) begin
                    act = pk(PC_addr, D_addr, RF_s, RF_W_data, RF_W_addr, RF_Ra_addr, RF_Rb_addr, ALU_s0);
                    n_cmp++;
                    if (q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_event: got en=%b vals=%h at cyc %0d, required no event", en, act, cnt);
                    end else begin
                        e = q.pop_front();
                        if (e.cyc != cnt || e.en != en || (act & e.msk) != (e.val & e.msk)) begin
                            n_bad++;
                            $display("FAIL event: got en=%b vals=%h at cyc %0d, required en=%b vals=%h mask=%h at cyc %0d",
                                     en, act, cnt, e.en, e.val, e.msk, e.cyc);
                        end
                    end
                end
            end
        join_none

        fill_rom(16'h7000);
        rom[0] = 16'h4A53;
        run(12, "ldi");

        fill_rom(16'h7000);
        rom[0] = 16'h2101; rom[1] = 16'h1102;
        run(14, "load_store");

        fill_rom(16'h7000);
        rom[0] = 16'h3123; rom[1] = 16'h5123;
        run(14, "add_sub");

        fill_rom(16'h7000);
        rom[0] = 16'h6250;
        zero_v = 16'h0004;
        run(10, "jmpz_taken");
        zero_v = 16'h0000;
        run(10, "jmpz_not_taken");

        for (int i = 0; i < 128; i++) rom[i] = (i % 3 == 0) ? 16'h9ABC : 16'h0000;
        run(300, "pc_wrap");

        fill_rom(16'h7000);
        run(25, "halt");

        // Reset dropped during LOAD_B must kill the register write at once.
        fill_rom(16'h7000);
        rom[0] = 16'h2101;
        begin
            bit h;
            int base;
            do_reset();
            base = cnt;
            model(base + 1, base + 4, h);
            while (cnt < base + 4) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            n_cmp++;
            if ({RF_W_wr, D_wr, D_rd, I_rd, state_o} !== {4'b0000, S_INIT}) begin
                n_bad++;
                $display("FAIL midop_reset: got wr=%b dwr=%b state=%0d, required 0 0 %0d", RF_W_wr, D_wr, state_o, S_INIT);
            end
            n_cmp++;
            if (q.size() != 0) begin
                n_bad++;
                $display("FAIL midop_events: got %0d pending, required 0", q.size());
            end
        end
        run(12, "after_abort");

        for (int p = 0; p < 12; p++) begin
            for (int i = 0; i < 128; i++) begin
                int o;
                o = $urandom_range(0, 11);
                rom[i] = $urandom;
                if (o < 8) rom[i][15:12] = 4'(o);
                else rom[i][15:12] = 4'($urandom_range(8, 15));
            end
            zero_v = 16'($urandom);
            run(200, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
